// File: rtl/n8_pkg.sv
`default_nettype none
// ============================================================================
// Module   : n8_pkg
// Brief    : Shared button order, pad FSM states and shift-image helper for
//            the n8 pad protocol (used by n8_pad_emulator and n8_driver).
// Revision : 1.0  initial release
// ============================================================================
package n8_pkg;

   localparam int NUM_BUTTONS = 8;

   // Serial bit order on the wire.
   typedef enum logic [2:0] {
      BTN_A      = 3'd0,
      BTN_B      = 3'd1,
      BTN_SELECT = 3'd2,
      BTN_START  = 3'd3,
      BTN_UP     = 3'd4,
      BTN_DOWN   = 3'd5,
      BTN_LEFT   = 3'd6,
      BTN_RIGHT  = 3'd7
   } btn_idx_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } pad_state_t;

   function automatic logic [NUM_BUTTONS-1:0] pad_shreg(
      input logic a, input logic b, input logic sel, input logic start,
      input logic up, input logic down, input logic left, input logic right);
      logic [NUM_BUTTONS-1:0] v;
      v             = '0;
      v[BTN_A]      = a;
      v[BTN_B]      = b;
      v[BTN_SELECT] = sel;
      v[BTN_START]  = start;
      v[BTN_UP]     = up;
      v[BTN_DOWN]   = down;
      v[BTN_LEFT]   = left;
      v[BTN_RIGHT]  = right;
      return ~v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/n8_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : n8_sync_edge
// Brief    : Multi-flop synchroniser with registered rise/fall pulses; the
//            level output is aligned with the pulses.
// Revision : 1.0  initial release
// ============================================================================
module n8_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic async_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   dly_q;
   logic                   rise_q;
   logic                   fall_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
         dly_q  <= 1'b0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
         dly_q  <= sync_q[SYNC_STAGES-1];
         rise_q <= sync_q[SYNC_STAGES-1] & ~dly_q;
         fall_q <= ~sync_q[SYNC_STAGES-1] & dly_q;
      end
   end

   assign level_o = dly_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule
`default_nettype wire

// File: rtl/n8_pad_emulator.sv
`default_nettype none
// ============================================================================
// Module   : n8_pad_emulator
// Brief    : Controller-side responder for the latch/pulse/data serial pad
//            protocol. Optional auto-fire: define N8_PAD_TURBO_EN.
// Revision : 1.0  initial release
// ============================================================================
module n8_pad_emulator
   import n8_pkg::*;
#(
   parameter int          SYNC_STAGES = 2,
   parameter logic        FILL_BIT    = 1'b0,
   parameter logic [15:0] TURBO_DIV   = 16'd50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       latch,
   input  logic       pulse,
   input  logic       btn_a,
   input  logic       btn_b,
   input  logic       btn_select,
   input  logic       btn_start,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       turbo_a,
   input  logic       turbo_b,
   output logic       data_out,
   output logic       frame_strobe,
   output logic [3:0] bit_idx
);

   logic w_latch_level;
   logic w_latch_rise;
   logic w_latch_fall;
   logic w_pulse_level;
   logic w_pulse_rise;
   logic w_pulse_fall;
   logic w_btn_a;
   logic w_btn_b;
   logic [NUM_BUTTONS-1:0] w_load;

   n8_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
      .clk     (clk),
      .reset   (reset),
      .async_i (latch),
      .level_o (w_latch_level),
      .rise_o  (w_latch_rise),
      .fall_o  (w_latch_fall)
   );

   n8_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_pulse (
      .clk     (clk),
      .reset   (reset),
      .async_i (pulse),
      .level_o (w_pulse_level),
      .rise_o  (w_pulse_rise),
      .fall_o  (w_pulse_fall)
   );

`ifdef N8_PAD_TURBO_EN
   logic [15:0] turbo_cnt_q;
   logic [15:0] turbo_cnt_d;
   logic        turbo_phase_q;
   logic        turbo_phase_d;

   always_comb begin
      turbo_cnt_d   = turbo_cnt_q + 16'd1;
      turbo_phase_d = turbo_phase_q;
      if (turbo_cnt_q == TURBO_DIV - 16'd1) begin
         turbo_cnt_d   = '0;
         turbo_phase_d = ~turbo_phase_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         turbo_cnt_q   <= '0;
         turbo_phase_q <= 1'b0;
      end else begin
         turbo_cnt_q   <= turbo_cnt_d;
         turbo_phase_q <= turbo_phase_d;
      end
   end

   // Auto-fire reports the button released during the active phase.
   assign w_btn_a = btn_a & ~(turbo_phase_q & turbo_a);
   assign w_btn_b = btn_b & ~(turbo_phase_q & turbo_b);
`else
   logic w_unused_turbo;
   assign w_unused_turbo = ^{turbo_a, turbo_b, TURBO_DIV};
   assign w_btn_a        = btn_a;
   assign w_btn_b        = btn_b;
`endif

   logic w_unused_levels;
   assign w_unused_levels = w_latch_level ^ w_pulse_level ^ w_pulse_fall;

   assign w_load = pad_shreg(w_btn_a, w_btn_b, btn_select, btn_start,
                             btn_up, btn_down, btn_left, btn_right);

   pad_state_t             state_q;
   logic [NUM_BUTTONS-1:0] shreg_q;
   logic                   data_q;
   logic [3:0]             bit_idx_q;
   logic                   strobe_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         shreg_q   <= 8'hFF;
         data_q    <= 1'b1;
         bit_idx_q <= 4'd0;
         strobe_q  <= 1'b0;
      end else begin
         strobe_q <= 1'b0;
         // A new latch abandons whatever frame is in progress.
         if (w_latch_rise) begin
            state_q   <= LOAD;
            shreg_q   <= w_load;
            data_q    <= w_load[0];
            bit_idx_q <= 4'd0;
         end else begin
            case (state_q)
               LOAD: begin
                  shreg_q   <= w_load;
                  data_q    <= w_load[0];
                  bit_idx_q <= 4'd0;
                  if (w_latch_fall) begin
                     state_q  <= SHIFT;
                     strobe_q <= 1'b1;
                  end
               end
               SHIFT: begin
                  if (w_pulse_rise) begin
                     shreg_q <= {1'b1, shreg_q[NUM_BUTTONS-1:1]};
                     if (bit_idx_q == 4'd7) begin
                        state_q   <= DONE;
                        bit_idx_q <= 4'd8;
                        data_q    <= FILL_BIT;
                     end else begin
                        bit_idx_q <= bit_idx_q + 4'd1;
                        data_q    <= shreg_q[1];
                     end
                  end
               end
               DONE:    data_q <= FILL_BIT;
               default: data_q <= 1'b1;
            endcase
         end
      end
   end

   assign data_out     = data_q;
   assign frame_strobe = strobe_q;
   assign bit_idx      = bit_idx_q;

endmodule
`default_nettype wire
